control_fsm: RTL
================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameters: CNT_W, default 32, width of the fetch counter.
REQ-002 clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  opcode of the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 ALUOp  output  2  to ALU_decoder: 00 add (lw/sw), 01 sub (beq), 10 funct-decoded.
REQ-008 ALUSrcA, ALUSrcB  output  2 each  ALU operand selects.
REQ-009 ResultSrc  output  2  result mux select.
REQ-010 AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite  output  1 each  datapath strobes.
REQ-011 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 state  output  4  current state code, for debug.
REQ-013 fetch_count  output  CNT_W  number of accepted instruction fetches.

Function
REQ-014 The block SHALL be a Moore FSM with registered state and combinational outputs; any output not listed for a state is 0.
REQ-015 FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00; IRWrite=mem_ready; PCUpdate=mem_ready; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-016 DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- 0000011/0100011 go to MEMADR.
- 0110011 goes to EXECR.
- 0010011 goes to EXECI.
- 1100011 goes to BEQ.
- 1101111 goes to JAL.
- Any other opcode goes to FETCH with illegal=1 for that cycle.
REQ-017 MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00; op[5]=0 goes to MEMREAD, op[5]=1 goes to MEMWRITE.
REQ-018 MEMREAD(3): AdrSrc=1, ResultSrc=00; holds until mem_ready=1, then goes to MEMWB.
REQ-019 MEMWB(4): ResultSrc=01, RegWrite=1; goes to FETCH.
REQ-020 MEMWRITE(5): AdrSrc=1, MemWrite=1 (held while waiting); holds until mem_ready=1, then goes to FETCH.
REQ-021 EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10; goes to ALUWB.
REQ-022 EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10; goes to ALUWB.
REQ-023 ALUWB(8): ResultSrc=00, RegWrite=1; goes to FETCH.
REQ-024 BEQ(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; goes to FETCH.
REQ-025 JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; goes to ALUWB.
REQ-026 PCWrite SHALL equal PCUpdate | (Branch & zero), where PCUpdate and Branch are internal signals.
REQ-027 Unused state codes 11-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-028 fetch_count SHALL increment by 1 on every edge where IRWrite=1, and wrap modulo 2^CNT_W.
REQ-029 Cycles per instruction with mem_ready=1 throughout:
- lw: 5
- sw: 4
- R-type / I-type: 4
- beq: 3
- jal: 4

Reset
REQ-030 While reset=1, state SHALL be FETCH and fetch_count SHALL be 0, immediately and without waiting for a clock edge.
REQ-031 Reset asserted mid-instruction SHALL abandon that instruction; no RegWrite, MemWrite or PCWrite SHALL be asserted while reset=1.
REQ-032 Immediately after reset, the outputs SHALL be the FETCH values with mem_ready gating.

Structure
REQ-033 State codes, the ALUOp encodings (00/01/10) and the opcode constants SHALL live in a shared control package that ALU_decoder also uses.
REQ-034 There SHALL be no sub-module; output decode SHALL be a single case statement on state.

Verification
REQ-035 Reset, then op=0110011 with mem_ready=1 → state sequence 0,1,6,8,0; ALUOp=10 in state 6; RegWrite=1 only in state 8; fetch_count=1.
REQ-036 op=0000011 with mem_ready held 0 for 3 cycles in MEMREAD → state 3 for 4 cycles, then 4; RegWrite=1 for exactly 1 cycle.
REQ-037 op=1100011: with zero=1, PCWrite=1 in state 9; with zero=0, PCWrite=0 in state 9; ALUOp=01.
REQ-038 op=1111111 → illegal=1 for one cycle in state 1, then state 0; no strobes asserted.
REQ-039 Assert reset during MEMWRITE with mem_ready=0 → state=0 and MemWrite=0 in the same cycle, fetch_count=0.
REQ-040 Preload fetch_count to all-ones (CNT_W=4 build) and perform one fetch → fetch_count=0.

Source files
------------

// File: rtl/control_fsm_pkg.sv
//------------------------------------------------------------------------------
// Module  : control_fsm_pkg
// Brief   : Shared control encodings: state codes, ALUOp values, opcodes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;

endpackage

`default_nettype wire

// File: rtl/control_fsm.sv
//------------------------------------------------------------------------------
// Module  : control_fsm
// Brief   : Multicycle RISC-V main control FSM with fetch counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             PCWrite,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] fetch_count
);

    state_t           r_state;
    state_t           w_next;
    logic             w_irwrite;
    logic             w_regwrite;
    logic             w_memwrite;
    logic             w_pcupdate;
    logic             w_branch;
    logic             w_illegal;
    logic [CNT_W-1:0] r_fetch_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_irwrite)
                r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = C_ALUOP_ADD;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_irwrite  = mem_ready;
                w_pcupdate = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    C_OP_LOAD,
                    C_OP_STORE:  w_next = S_MEMADR;
                    C_OP_RTYPE:  w_next = S_EXECR;
                    C_OP_ITYPE:  w_next = S_EXECI;
                    C_OP_BRANCH: w_next = S_BEQ;
                    C_OP_JAL:    w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                // op[5] separates stores from loads
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = C_ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = C_ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = C_ALUOP_SUB;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are suppressed while reset is held so no side effect escapes
    assign IRWrite     = ~reset & w_irwrite;
    assign RegWrite    = ~reset & w_regwrite;
    assign MemWrite    = ~reset & w_memwrite;
    assign PCWrite     = ~reset & (w_pcupdate | (w_branch & zero));
    assign illegal     = ~reset & w_illegal;
    assign state       = r_state;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire
